// File: rtl/div_controller_if.sv
// Start/done handshake between the EX-stage divide controller and the iterative divider.
// The controller is the master and the divider is the slave.
interface div_controller_if;
   logic [31:0] div_dividend;
   logic [31:0] div_divisor;
   logic        div_is_unsigned;
   logic        div_start;
   logic        div_done;
   logic [31:0] div_val;
   logic [31:0] div_rem;

   modport master (
      output div_dividend,
      output div_divisor,
      output div_is_unsigned,
      output div_start,
      input  div_done,
      input  div_val,
      input  div_rem
   );

   modport slave (
      input  div_dividend,
      input  div_divisor,
      input  div_is_unsigned,
      input  div_start,
      output div_done,
      output div_val,
      output div_rem
   );
endinterface

// File: rtl/div_controller.sv
// Issues RV32M DIV/DIVU/REM/REMU to an iterative divider, stalls EX until done, and
// resolves divide-by-zero and signed overflow locally without starting the divider.
module div_controller #(
   parameter int unsigned RESET_GUARD = 36
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_valid,
   input  logic [2:0]              funct3,
   input  logic [31:0]             rs1,
   input  logic [31:0]             rs2,
   input  logic [4:0]              rd,
   input  logic                    flush,
   output logic                    stall,
   output logic                    result_valid,
   output logic [31:0]             result,
   output logic [4:0]              result_rd,
   div_controller_if.master        div
);

   localparam int unsigned GuardW = $clog2(RESET_GUARD + 1);

   typedef enum logic [2:0] {StIdle, StIssue, StWait, StDrain, StResp} state_e;

   state_e              state_q;
   logic [GuardW-1:0]   guard_q;
   logic                start_q;
   logic [31:0]         result_q;
   logic [4:0]          rd_q;
   logic [31:0]         dividend_q;
   logic [31:0]         divisor_q;
   logic                uns_q;
   logic                is_rem_q;

   logic                idle;
   logic                guard_zero;
   logic                is_div_req;
   logic                accept;
   logic                div_by_zero;
   logic                overflow;
   logic                bypass;
   logic [31:0]         bypass_res;

   always_comb begin
      idle        = (state_q == StIdle);
      guard_zero  = (guard_q == '0);
      is_div_req  = req_valid & funct3[2];
      accept      = idle & guard_zero & is_div_req & ~flush;
      div_by_zero = (rs2 == 32'h0);
      overflow    = ~funct3[0] & (rs1 == 32'h8000_0000) & (rs2 == 32'hFFFF_FFFF);
      bypass      = div_by_zero | overflow;
      if (div_by_zero) begin
         bypass_res = funct3[1] ? rs1 : 32'hFFFF_FFFF;
      end else begin
         bypass_res = funct3[1] ? 32'h0 : 32'h8000_0000;
      end
   end

   // While the guard runs, a pending divide still stalls so it is not lost.
   always_comb begin
      stall = accept
            | (idle & ~guard_zero & is_div_req)
            | (state_q == StIssue)
            | (state_q == StWait)
            | (state_q == StDrain);
      result_valid = (state_q == StResp) & ~flush;
   end

   assign result              = result_q;
   assign result_rd           = rd_q;
   assign div.div_dividend    = dividend_q;
   assign div.div_divisor     = divisor_q;
   assign div.div_is_unsigned = uns_q;
   assign div.div_start       = start_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         guard_q    <= GuardW'(RESET_GUARD);
         start_q    <= 1'b0;
         result_q   <= '0;
         rd_q       <= '0;
         dividend_q <= '0;
         divisor_q  <= '0;
         uns_q      <= 1'b0;
         is_rem_q   <= 1'b0;
      end else begin
         start_q <= 1'b0;
         if (!guard_zero) begin
            guard_q <= guard_q - GuardW'(1);
         end
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  dividend_q <= rs1;
                  divisor_q  <= rs2;
                  rd_q       <= rd;
                  is_rem_q   <= funct3[1];
                  uns_q      <= funct3[0];
                  if (bypass) begin
                     result_q <= bypass_res;
                     state_q  <= StResp;
                  end else begin
                     start_q <= 1'b1;
                     state_q <= StIssue;
                  end
               end
            end
            StIssue: begin
               state_q <= flush ? StDrain : StWait;
            end
            StWait: begin
               if (div.div_done && flush) begin
                  state_q <= StIdle;
               end else if (div.div_done) begin
                  result_q <= is_rem_q ? div.div_rem : div.div_val;
                  state_q  <= StResp;
               end else if (flush) begin
                  state_q <= StDrain;
               end
            end
            // Divider cannot be aborted; let the killed run finish before reuse.
            StDrain: begin
               if (div.div_done) begin
                  state_q <= StIdle;
               end
            end
            StResp: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_controller.sv
// Scoreboard bench for div_controller with a behavioural 34-cycle divider that ignores rst_n.
module tb_div_controller;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic [2:0]  funct3;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic [4:0]  rd;
   logic        flush;
   logic        stall;
   logic        result_valid;
   logic [31:0] result;
   logic [4:0]  result_rd;

   div_controller_if dif ();

   div_controller #(
      .RESET_GUARD (36)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .funct3       (funct3),
      .rs1          (rs1),
      .rs2          (rs2),
      .rd           (rd),
      .flush        (flush),
      .stall        (stall),
      .result_valid (result_valid),
      .result       (result),
      .result_rd    (result_rd),
      .div          (dif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Divider model: done 34 cycles after the start cycle; not reset by rst_n.
   logic [5:0]  dcnt = 6'd0;
   logic [31:0] dv;
   logic [31:0] dr;
   always @(posedge clk) begin
      if (dif.div_start) dcnt <= 6'd34;
      else if (dcnt != 6'd0) dcnt <= dcnt - 6'd1;
   end
   always_comb begin
      dv = '0;
      dr = '0;
      if (dif.div_divisor != 32'h0 &&
          !(!dif.div_is_unsigned && dif.div_dividend == 32'h8000_0000 &&
            dif.div_divisor == 32'hFFFF_FFFF)) begin
         if (dif.div_is_unsigned) begin
            dv = dif.div_dividend / dif.div_divisor;
            dr = dif.div_dividend % dif.div_divisor;
         end else begin
            dv = $signed(dif.div_dividend) / $signed(dif.div_divisor);
            dr = $signed(dif.div_dividend) % $signed(dif.div_divisor);
         end
      end
   end
   assign dif.div_done = (dcnt == 6'd1);
   assign dif.div_val  = dv;
   assign dif.div_rem  = dr;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   start_cnt = 0;
   int   last_start = -1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT strobes a result.
   always @(negedge clk) begin
      exp_t item;
      if (dif.div_start) begin
         start_cnt++;
         last_start = cyc;
      end
      if (result_valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_result", result, 32'hxxxx_xxxx);
         end else begin
            item = sb.pop_front();
            chk("result", result, item.res);
            chk("result_rd", {27'h0, result_rd}, {27'h0, item.rd});
            chk("result_cycle", cyc, item.cyc);
            chk("resp_stall", {31'h0, stall}, 32'h0);
         end
      end
   end

   task automatic do_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r, input logic [31:0] exp, input int lat);
      int c;
      int s0;
      int lows;
      @(posedge clk); #1;
      req_valid = 1'b1; funct3 = f3; rs1 = a; rs2 = b; rd = r;
      c = cyc; s0 = start_cnt;
      sb.push_back('{exp, r, c + lat});
      @(negedge clk);
      chk("accept_stall", {31'h0, stall}, 32'h1);
      @(posedge clk); #1;
      req_valid = 1'b0; funct3 = 3'b000;
      lows = 0;
      while (cyc < c + lat) begin
         @(negedge clk);
         if (cyc < c + lat && !stall) lows++;
      end
      @(posedge clk); #1;
      chk("resp_pending", sb.size(), 0);
      sb.delete();
      chk("stall_held", lows, 0);
      chk("start_pulses", start_cnt - s0, (lat == 1) ? 0 : 1);
      if (lat != 1) chk("start_cycle", last_start, c + 1);
   endtask

   task automatic chk_reset_outputs(input logic exp_stall);
      chk("rst_stall", {31'h0, stall}, {31'h0, exp_stall});
      chk("rst_result_valid", {31'h0, result_valid}, 32'h0);
      chk("rst_div_start", {31'h0, dif.div_start}, 32'h0);
      chk("rst_result", result, 32'h0);
      chk("rst_result_rd", {27'h0, result_rd}, 32'h0);
      chk("rst_dividend", dif.div_dividend, 32'h0);
      chk("rst_divisor", dif.div_divisor, 32'h0);
      chk("rst_unsigned", {31'h0, dif.div_is_unsigned}, 32'h0);
   endtask

   initial begin
      int c;
      int r;
      int s0;
      int lows;
      rst_n = 1'b0; req_valid = 1'b0; funct3 = 3'b000; rs1 = '0; rs2 = '0; rd = '0;
      flush = 1'b0;
      #3;
      chk_reset_outputs(1'b0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (40) @(posedge clk);

      // Normal divides, signed and unsigned
      do_req(3'b101, 32'd100, 32'd7, 5'd1, 32'd14, 36);
      chk("held_dividend", dif.div_dividend, 32'd100);
      chk("held_divisor", dif.div_divisor, 32'd7);
      chk("held_unsigned", {31'h0, dif.div_is_unsigned}, 32'h1);
      do_req(3'b111, 32'd100, 32'd7, 5'd2, 32'd2, 36);
      do_req(3'b100, 32'hFFFF_FF9C, 32'd7, 5'd3, 32'hFFFF_FFF2, 36);
      do_req(3'b110, 32'hFFFF_FF9C, 32'd7, 5'd4, 32'hFFFF_FFFE, 36);

      // Local bypass: divide by zero and signed overflow
      do_req(3'b100, 32'd5, 32'd0, 5'd5, 32'hFFFF_FFFF, 1);
      do_req(3'b110, 32'd5, 32'd0, 5'd6, 32'd5, 1);
      do_req(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32'h8000_0000, 1);
      do_req(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h0, 1);

      // Flush while waiting: drain, then a fresh request right after done
      @(posedge clk); #1;
      req_valid = 1'b1; funct3 = 3'b101; rs1 = 32'd50; rs2 = 32'd5; rd = 5'd9;
      c = cyc; s0 = start_cnt;
      @(posedge clk); #1;
      req_valid = 1'b0; funct3 = 3'b000;
      repeat (9) @(posedge clk);
      #1 flush = 1'b1;
      @(negedge clk);
      chk("flush_stall", {31'h0, stall}, 32'h1);
      @(posedge clk); #1 flush = 1'b0;
      lows = 0;
      while (cyc < c + 35) begin
         @(negedge clk);
         if (!stall) lows++;
      end
      chk("drain_stall_held", lows, 0);
      chk("drain_start_pulses", start_cnt - s0, 1);
      do_req(3'b101, 32'd9, 32'd3, 5'd10, 32'd3, 36);

      // Reset mid-run with a request held through the guard window
      @(posedge clk); #1;
      req_valid = 1'b1; funct3 = 3'b101; rs1 = 32'd100; rs2 = 32'd7; rd = 5'd11;
      s0 = start_cnt;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      req_valid = 1'b1; funct3 = 3'b101; rs1 = 32'd9; rs2 = 32'd3; rd = 5'd12;
      #1;
      chk_reset_outputs(1'b1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      r = cyc;
      sb.push_back('{32'd3, 5'd12, r + 72});
      lows = 0;
      while (cyc < r + 36) begin
         @(negedge clk);
         if (!stall) lows++;
      end
      @(posedge clk); #1;
      req_valid = 1'b0; funct3 = 3'b000;
      while (cyc < r + 72) begin
         @(negedge clk);
         if (cyc < r + 72 && !stall) lows++;
      end
      @(posedge clk); #1;
      chk("guard_resp_pending", sb.size(), 0);
      sb.delete();
      chk("guard_stall_held", lows, 0);
      chk("guard_start_pulses", start_cnt - s0, 2);
      chk("guard_start_cycle", last_start, r + 37);

      // Non-divide funct3 is ignored
      s0 = start_cnt;
      req_valid = 1'b1; funct3 = 3'b000; rs1 = 32'd8; rs2 = 32'd2; rd = 5'd13;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("nondiv_stall", {31'h0, stall}, 32'h0);
      end
      @(posedge clk); #1 req_valid = 1'b0;
      repeat (3) @(posedge clk);
      chk("nondiv_no_start", start_cnt - s0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

endmodule
